// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - writeback FIFO in front of the register file write port, with read bypass
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       drain_en,
    output logic                       rf_writeEn,
    output logic [ADDR_W-1:0]          rf_rd,
    output logic [DATA_W-1:0]          rf_dataIn,
    input  logic [ADDR_W-1:0]          rs1,
    input  logic [ADDR_W-1:0]          rs2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          fwd1,
    output logic [DATA_W-1:0]          fwd2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop, empty;

    assign empty      = (count_q == '0);
    // Ready depends only on registered occupancy so drain_en never reaches in_ready.
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign rf_writeEn = !empty && drain_en;
    assign rf_rd      = empty ? '0 : rd_q[head_q];
    assign rf_dataIn  = empty ? '0 : data_q[head_q];
    assign count      = count_q;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push    = in_valid && in_ready && (in_rd != '0);
    assign pop     = rf_writeEn;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Pointer, occupancy and entry storage update; reset drops every queued write.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                rd_q[tail_q]    <= in_rd;
                data_q[tail_q]  <= in_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
        end
    end

    // Bypass lookup: walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && rs1 != '0 && rd_q[idx] == rs1) begin
                hit1 = 1'b1;
                fwd1 = data_q[idx];
            end
            if (valid_q[idx] && rs2 != '0 && rd_q[idx] == rs2) begin
                hit2 = 1'b1;
                fwd2 = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed vector bench for regfile_write_queue
module tb_regfile_write_queue;
    logic        clk = 1'b0;
    logic        r;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en;
    logic        rf_writeEn;
    logic [4:0]  rf_rd;
    logic [31:0] rf_dataIn;
    logic [4:0]  rs1, rs2;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    regfile_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .r(r),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en),
        .rf_writeEn(rf_writeEn), .rf_rd(rf_rd), .rf_dataIn(rf_dataIn),
        .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        de;
        logic [4:0]  s1, s2;
        logic        rdy, we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic v, logic [4:0] rd, logic [31:0] d, logic de,
                                logic [4:0] s1, logic [4:0] s2, logic rdy, logic we,
                                logic [4:0] wrd, logic [31:0] wd, logic h1, logic [31:0] f1,
                                logic h2, logic [31:0] f2, logic [2:0] cnt);
        vec_t t;
        t.v = v; t.rd = rd; t.d = d; t.de = de; t.s1 = s1; t.s2 = s2;
        t.rdy = rdy; t.we = we; t.wrd = wrd; t.wd = wd;
        t.h1 = h1; t.f1 = f1; t.h2 = h2; t.f2 = f2; t.cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic de, input logic [4:0] s1, input logic [4:0] s2);
        in_valid = v; in_rd = rd; in_data = d; drain_en = de; rs1 = s1; rs2 = s2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // reset then idle
        next_cycle();
        next_cycle();
        r = 1'b1;
        drive(0, 0, 0, 0, 1, 2);
        @(negedge clk);
        check("idle.in_ready", 32'(in_ready), 32'd1);
        check("idle.count", 32'(count), 32'd0);
        check("idle.we", 32'(rf_writeEn), 32'd0);
        check("idle.hit1", 32'(hit1), 32'd0);
        check("idle.hit2", 32'(hit2), 32'd0);
        check("idle.rf_rd", 32'(rf_rd), 32'd0);
        next_cycle();

        // single write latency
        drive(1, 1, 32'h28111172, 1, 0, 0);
        @(negedge clk);
        check("single.we_cycle0", 32'(rf_writeEn), 32'd0);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("single.we", 32'(rf_writeEn), 32'd1);
        check("single.rf_rd", 32'(rf_rd), 32'd1);
        check("single.rf_data", rf_dataIn, 32'h28111172);
        next_cycle();
        @(negedge clk);
        check("single.count_after", 32'(count), 32'd0);
        check("single.we_after", 32'(rf_writeEn), 32'd0);
        next_cycle();

        // stall/bypass, full boundary, x0 discard
        vq.push_back(mk(1, 1, 32'h28111172, 0, 1, 2, 1, 0, 0, 0,            0, 0,            0, 0,            0));
        vq.push_back(mk(1, 2, 32'h22857572, 0, 1, 2, 1, 0, 1, 32'h28111172, 1, 32'h28111172, 0, 0,            1));
        vq.push_back(mk(1, 1, 32'hDEADBEEF, 0, 1, 2, 1, 0, 1, 32'h28111172, 1, 32'h28111172, 1, 32'h22857572, 2));
        vq.push_back(mk(0, 0, 0,            0, 1, 2, 1, 0, 1, 32'h28111172, 1, 32'hDEADBEEF, 1, 32'h22857572, 3));
        vq.push_back(mk(0, 0, 0,            1, 1, 2, 1, 1, 1, 32'h28111172, 1, 32'hDEADBEEF, 1, 32'h22857572, 3));
        vq.push_back(mk(0, 0, 0,            1, 1, 2, 1, 1, 2, 32'h22857572, 1, 32'hDEADBEEF, 1, 32'h22857572, 2));
        vq.push_back(mk(0, 0, 0,            1, 1, 2, 1, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,            1));
        vq.push_back(mk(0, 0, 0,            1, 1, 2, 1, 0, 0, 0,            0, 0,            0, 0,            0));
        vq.push_back(mk(1, 3, 32'hA0000003, 0, 3, 6, 1, 0, 0, 0,            0, 0,            0, 0,            0));
        vq.push_back(mk(1, 4, 32'hA0000004, 0, 3, 6, 1, 0, 3, 32'hA0000003, 1, 32'hA0000003, 0, 0,            1));
        vq.push_back(mk(1, 5, 32'hA0000005, 0, 3, 6, 1, 0, 3, 32'hA0000003, 1, 32'hA0000003, 0, 0,            2));
        vq.push_back(mk(1, 6, 32'hA0000006, 0, 3, 6, 1, 0, 3, 32'hA0000003, 1, 32'hA0000003, 0, 0,            3));
        vq.push_back(mk(1, 7, 32'hA0000007, 0, 3, 6, 0, 0, 3, 32'hA0000003, 1, 32'hA0000003, 1, 32'hA0000006, 4));
        vq.push_back(mk(1, 7, 32'hA0000007, 1, 3, 6, 0, 1, 3, 32'hA0000003, 1, 32'hA0000003, 1, 32'hA0000006, 4));
        vq.push_back(mk(1, 7, 32'hA0000007, 0, 3, 6, 1, 0, 4, 32'hA0000004, 0, 0,            1, 32'hA0000006, 3));
        vq.push_back(mk(0, 0, 0,            0, 7, 3, 0, 0, 4, 32'hA0000004, 1, 32'hA0000007, 0, 0,            4));
        vq.push_back(mk(0, 0, 0,            1, 0, 5, 0, 1, 4, 32'hA0000004, 0, 0,            1, 32'hA0000005, 4));
        vq.push_back(mk(1, 0, 32'h12345678, 1, 0, 0, 1, 1, 5, 32'hA0000005, 0, 0,            0, 0,            3));
        vq.push_back(mk(0, 0, 0,            1, 0, 7, 1, 1, 6, 32'hA0000006, 0, 0,            1, 32'hA0000007, 2));
        vq.push_back(mk(0, 0, 0,            1, 0, 7, 1, 1, 7, 32'hA0000007, 0, 0,            1, 32'hA0000007, 1));
        vq.push_back(mk(0, 0, 0,            0, 0, 7, 1, 0, 0, 0,            0, 0,            0, 0,            0));
        vq.push_back(mk(1, 0, 32'h12345678, 1, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,            0));
        vq.push_back(mk(0, 0, 0,            1, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,            0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v, vq[i].rd, vq[i].d, vq[i].de, vq[i].s1, vq[i].s2);
            @(negedge clk);
            check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vq[i].rdy));
            check($sformatf("v%0d.we", i), 32'(rf_writeEn), 32'(vq[i].we));
            check($sformatf("v%0d.rf_rd", i), 32'(rf_rd), 32'(vq[i].wrd));
            check($sformatf("v%0d.rf_data", i), rf_dataIn, vq[i].wd);
            check($sformatf("v%0d.hit1", i), 32'(hit1), 32'(vq[i].h1));
            check($sformatf("v%0d.fwd1", i), fwd1, vq[i].f1);
            check($sformatf("v%0d.hit2", i), 32'(hit2), 32'(vq[i].h2));
            check($sformatf("v%0d.fwd2", i), fwd2, vq[i].f2);
            check($sformatf("v%0d.count", i), 32'(count), 32'(vq[i].cnt));
            next_cycle();
        end

        // reset asserted with three entries queued
        for (int k = 1; k <= 3; k++) begin
            drive(1, 5'(k + 8), 32'hB0000000 + k, 0, 9, 0);
            next_cycle();
        end
        drive(0, 0, 0, 1, 9, 0);
        @(negedge clk);
        check("rst_mid.count_before", 32'(count), 32'd3);
        r = 1'b0;
        #1;
        check("rst_mid.count", 32'(count), 32'd0);
        check("rst_mid.we", 32'(rf_writeEn), 32'd0);
        check("rst_mid.hit1", 32'(hit1), 32'd0);
        next_cycle();
        r = 1'b1;
        @(negedge clk);
        check("rst_mid.count_rel", 32'(count), 32'd0);
        check("rst_mid.we_rel", 32'(rf_writeEn), 32'd0);
        next_cycle();

        // back-to-back stream with concurrent push/pop, pointers wrap twice
        for (int c = 0; c < 12; c++) begin
            if (c < 10) drive(1, 5'(c + 1), 32'h11111111 * (c + 1), 1, 0, 0);
            else        drive(0, 0, 0, 1, 0, 0);
            @(negedge clk);
            if (c == 0 || c == 11) begin
                check($sformatf("stream%0d.we", c), 32'(rf_writeEn), 32'd0);
                check($sformatf("stream%0d.count", c), 32'(count), 32'd0);
            end else begin
                check($sformatf("stream%0d.we", c), 32'(rf_writeEn), 32'd1);
                check($sformatf("stream%0d.rf_rd", c), 32'(rf_rd), 32'(c));
                check($sformatf("stream%0d.rf_data", c), rf_dataIn, 32'h11111111 * c);
                check($sformatf("stream%0d.count", c), 32'(count), 32'd1);
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
